// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding and register constants for the APB priority arbiter
package arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARB     = 2'b01,
    S_GRANT   = 2'b10,
    S_RELEASE = 2'b11
  } state_e;

  localparam logic [7:0] ADDR_CTRL   = 8'h10;
  localparam logic [7:0] ADDR_STATUS = 8'h11;
  localparam int         PRIO_W      = 4;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational max-priority pick with rotating tie-break
module arb_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 8
) (
  input  logic [NUM_REQ-1:0]             elig_i,
  input  logic [NUM_REQ-1:0][PRIO_W-1:0] prio_i,
  input  logic [3:0]                     rr_ptr_i,
  output logic [3:0]                     winner_o,
  output logic                           found_o
);

  logic [PRIO_W-1:0]  max_p;
  logic [NUM_REQ-1:0] cand;
  logic               found;
  logic [3:0]         win;

  always_comb begin
    max_p = '0;
    cand  = '0;
    found = 1'b0;
    win   = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (elig_i[n] && prio_i[n] > max_p) max_p = prio_i[n];
    end
    for (int n = 0; n < NUM_REQ; n++) begin
      cand[n] = elig_i[n] && (prio_i[n] == max_p);
    end
    // First pass covers rr_ptr..top, second pass wraps to the lowest tied index.
    for (int n = 0; n < NUM_REQ; n++) begin
      if (!found && cand[n] && n >= int'(rr_ptr_i)) begin
        found = 1'b1;
        win   = 4'(n);
      end
    end
    for (int n = 0; n < NUM_REQ; n++) begin
      if (!found && cand[n]) begin
        found = 1'b1;
        win   = 4'(n);
      end
    end
    winner_o = win;
    found_o  = found;
  end

endmodule

// File: rtl/apb_priority_arbiter.sv
// rtl/apb_priority_arbiter.sv - APB-programmable priority arbiter with hold timeout and interrupt
module apb_priority_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 8,
  parameter int HOLD_MAX = 255
) (
  input  logic               pclk_i,
  input  logic               prst_i,
  input  logic               psel_i,
  input  logic               penable_i,
  input  logic               pwrite_i,
  input  logic [7:0]         paddr_i,
  input  logic [7:0]         pwdata_i,
  output logic [7:0]         prdata_o,
  output logic               pready_o,
  output logic               pslverr_o,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [3:0]         gnt_id_o,
  output logic               gnt_valid_o,
  input  logic               done_i,
  output logic               timeout_irq_o
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  localparam logic [3:0] LAST_ID   = 4'(NUM_REQ - 1);

  state_e                         state_q, state_d;
  logic [NUM_REQ-1:0][PRIO_W-1:0] prio_q;
  logic [1:0]                     ctrl_q;
  logic [3:0]                     rr_q, rr_d, win_q, win_d;
  logic [7:0]                     hold_q, hold_d;
  logic [NUM_REQ-1:0]             gnt_q, gnt_d;
  logic [3:0]                     gnt_id_q, gnt_id_d;
  logic                           gnt_valid_q, gnt_valid_d;
  logic                           tflag_q, tflag_set, tflag_clr;
  logic [7:0]                     prdata_q, rd_mux;

  logic [NUM_REQ-1:0] elig, pick_oh;
  logic [3:0]         pick_id;
  logic               pick_found;
  logic               access, wr_en, prio_hit, mapped;

  always_comb begin
    elig    = '0;
    pick_oh = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      elig[n]    = req_i[n] && (prio_q[n] != '0);
      pick_oh[n] = (pick_id == 4'(n));
    end
  end

  // With rr_en clear the search starts at index 0, i.e. lowest index wins ties.
  arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .elig_i   (elig),
    .prio_i   (prio_q),
    .rr_ptr_i (ctrl_q[1] ? rr_q : 4'd0),
    .winner_o (pick_id),
    .found_o  (pick_found)
  );

  always_comb begin
    access    = psel_i && penable_i;
    prio_hit  = (paddr_i < 8'(NUM_REQ));
    mapped    = prio_hit || (paddr_i == ADDR_CTRL) || (paddr_i == ADDR_STATUS);
    wr_en     = access && pwrite_i && mapped;
    tflag_clr = wr_en && (paddr_i == ADDR_STATUS) && pwdata_i[5];
    rd_mux    = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (paddr_i == 8'(n)) rd_mux = {{(8-PRIO_W){1'b0}}, prio_q[n]};
    end
    if (paddr_i == ADDR_CTRL)   rd_mux = {6'b0, ctrl_q};
    if (paddr_i == ADDR_STATUS) rd_mux = {2'b0, tflag_q, gnt_valid_q, gnt_id_q};
  end

  assign pready_o      = access;
  assign pslverr_o     = access && !mapped;
  assign prdata_o      = prdata_q;
  assign gnt_o         = gnt_q;
  assign gnt_id_o      = gnt_id_q;
  assign gnt_valid_o   = gnt_valid_q;
  assign timeout_irq_o = tflag_q;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    win_d       = win_q;
    hold_d      = hold_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    tflag_set   = 1'b0;
    case (state_q)
      S_IDLE: if (ctrl_q[0] && |elig) state_d = S_ARB;
      S_ARB: begin
        if (pick_found) begin
          state_d     = S_GRANT;
          win_d       = pick_id;
          gnt_d       = pick_oh;
          gnt_id_d    = pick_id;
          gnt_valid_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        hold_d = hold_q + 8'd1;
        // done on the final hold cycle releases cleanly without flagging a timeout
        if (done_i || hold_q == HOLD_LAST) begin
          tflag_set   = !done_i;
          state_d     = S_RELEASE;
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
        end
      end
      S_RELEASE: begin
        rr_d    = (win_q == LAST_ID) ? 4'd0 : win_q + 4'd1;
        hold_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      state_q     <= S_IDLE;
      prio_q      <= '0;
      ctrl_q      <= 2'b01;
      rr_q        <= '0;
      win_q       <= '0;
      hold_q      <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      tflag_q     <= 1'b0;
      prdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      win_q       <= win_d;
      hold_q      <= hold_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      tflag_q     <= tflag_set || (tflag_q && !tflag_clr);
      prdata_q    <= (psel_i && !penable_i && !pwrite_i) ? rd_mux : '0;
      if (wr_en) begin
        for (int n = 0; n < NUM_REQ; n++) begin
          if (paddr_i == 8'(n)) prio_q[n] <= pwdata_i[PRIO_W-1:0];
        end
        if (paddr_i == ADDR_CTRL) ctrl_q <= pwdata_i[1:0];
      end
    end
  end

endmodule

// File: tb/tb_apb_priority_arbiter.sv
// tb/tb_apb_priority_arbiter.sv - scoreboard testbench for apb_priority_arbiter
module tb_apb_priority_arbiter;

  logic       pclk_i = 1'b0;
  logic       prst_i = 1'b0;
  logic       psel_i = 1'b0;
  logic       penable_i = 1'b0;
  logic       pwrite_i = 1'b0;
  logic [7:0] paddr_i = '0;
  logic [7:0] pwdata_i = '0;
  logic [7:0] prdata_o;
  logic       pready_o;
  logic       pslverr_o;
  logic [7:0] req_i = '0;
  logic [7:0] gnt_o;
  logic [3:0] gnt_id_o;
  logic       gnt_valid_o;
  logic       done_i = 1'b0;
  logic       timeout_irq_o;

  int total = 0;
  int bad = 0;
  int exp_q[$];

  logic [7:0] rd;
  logic       er, rdy;

  apb_priority_arbiter #(.NUM_REQ(8), .HOLD_MAX(4)) dut (
    .pclk_i        (pclk_i),
    .prst_i        (prst_i),
    .psel_i        (psel_i),
    .penable_i     (penable_i),
    .pwrite_i      (pwrite_i),
    .paddr_i       (paddr_i),
    .pwdata_i      (pwdata_i),
    .prdata_o      (prdata_o),
    .pready_o      (pready_o),
    .pslverr_o     (pslverr_o),
    .req_i         (req_i),
    .gnt_o         (gnt_o),
    .gnt_id_o      (gnt_id_o),
    .gnt_valid_o   (gnt_valid_o),
    .done_i        (done_i),
    .timeout_irq_o (timeout_irq_o)
  );

  always #5 pclk_i = ~pclk_i;

  // Grant scoreboard: every new grant must match the next expected requester.
  logic prev_v = 1'b0;
  always @(negedge pclk_i) begin
    int         exp_id;
    logic [7:0] oh;
    if (gnt_valid_o && !prev_v) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL grant_unexpected: got id=%0d gnt=%02h, required no grant", gnt_id_o, gnt_o);
      end else begin
        exp_id = exp_q.pop_front();
        oh = 8'd1 << exp_id[2:0];
        if (gnt_id_o !== 4'(exp_id) || gnt_o !== oh) begin
          bad++;
          $display("FAIL grant_order: got id=%0d gnt=%02h, required id=%0d gnt=%02h", gnt_id_o, gnt_o, exp_id, oh);
        end
      end
    end
    prev_v = gnt_valid_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apb_write(input logic [7:0] addr, input logic [7:0] data);
    @(posedge pclk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = addr; pwdata_i = data;
    @(posedge pclk_i); #1;
    penable_i = 1'b1;
    @(posedge pclk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] addr, output logic [7:0] data, output logic err, output logic ready);
    @(posedge pclk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = addr;
    @(posedge pclk_i); #1;
    penable_i = 1'b1;
    @(negedge pclk_i);
    data = prdata_o; err = pslverr_o; ready = pready_o;
    @(posedge pclk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  task automatic wait_grant();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge pclk_i);
      if (gnt_valid_o) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL wait_grant: gnt_valid_o=0 after 20 cycles, required 1");
    end
  endtask

  task automatic release_grant(input logic [7:0] new_req);
    @(posedge pclk_i); #1;
    done_i = 1'b1; req_i = new_req;
    @(posedge pclk_i); #1;
    done_i = 1'b0;
    @(negedge pclk_i);
    total++;
    if (gnt_valid_o !== 1'b0 || gnt_o !== 8'h00) begin
      bad++;
      $display("FAIL release: got valid=%b gnt=%02h, required valid=0 gnt=00", gnt_valid_o, gnt_o);
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({gnt_o, gnt_id_o, gnt_valid_o, timeout_irq_o, prdata_o, pready_o, pslverr_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: gnt=%02h id=%0d v=%b irq=%b prdata=%02h rdy=%b err=%b, required all 0",
               gnt_o, gnt_id_o, gnt_valid_o, timeout_irq_o, prdata_o, pready_o, pslverr_o);
    end
    repeat (2) @(negedge pclk_i);
    prst_i = 1'b1;
    apb_read(8'h10, rd, er, rdy);
    total++;
    if ({rdy, er, rd} !== {1'b1, 1'b0, 8'h01}) begin
      bad++; $display("FAIL reset_ctrl: got rdy=%b err=%b data=%02h, required 1 0 01", rdy, er, rd);
    end
    apb_read(8'h03, rd, er, rdy);
    total++;
    if ({er, rd} !== 9'h000) begin
      bad++; $display("FAIL reset_prio3: got err=%b data=%02h, required 0 00", er, rd);
    end
    apb_read(8'h20, rd, er, rdy);
    total++;
    if ({rdy, er, rd} !== {1'b1, 1'b1, 8'h00}) begin
      bad++; $display("FAIL unmapped_read: got rdy=%b err=%b data=%02h, required 1 1 00", rdy, er, rd);
    end
    apb_read(8'h11, rd, er, rdy);
    total++;
    if ({er, rd} !== 9'h000) begin
      bad++; $display("FAIL reset_status: got err=%b data=%02h, required 0 00", er, rd);
    end
  endtask

  task automatic test_priority();
    apb_write(8'h02, 8'd5);
    apb_write(8'h06, 8'd9);
    exp_q.push_back(6);
    @(posedge pclk_i); #1;
    req_i = 8'h44;
    for (int c = 0; c < 2; c++) begin
      @(negedge pclk_i);
      total++;
      if (gnt_o !== 8'h00) begin
        bad++; $display("FAIL latency_early: cycle N+%0d gnt=%02h, required 00", c, gnt_o);
      end
    end
    @(negedge pclk_i);
    total++;
    if (gnt_o !== 8'h40 || gnt_id_o !== 4'd6) begin
      bad++; $display("FAIL latency_n2: got gnt=%02h id=%0d, required 40 6", gnt_o, gnt_id_o);
    end
    exp_q.push_back(2);
    release_grant(8'h04);
    for (int c = 0; c < 2; c++) begin
      @(negedge pclk_i);
      total++;
      if (gnt_o !== 8'h00) begin
        bad++; $display("FAIL spacing_early: cycle %0d after release gnt=%02h, required 00", c + 1, gnt_o);
      end
    end
    @(negedge pclk_i);
    total++;
    if (gnt_o !== 8'h04) begin
      bad++; $display("FAIL spacing_grant: got gnt=%02h, required 04", gnt_o);
    end
    release_grant(8'h00);
  endtask

  task automatic test_round_robin();
    @(negedge pclk_i); prst_i = 1'b0;
    @(negedge pclk_i); prst_i = 1'b1;
    apb_write(8'h01, 8'd4);
    apb_write(8'h03, 8'd4);
    apb_write(8'h05, 8'd4);
    apb_write(8'h10, 8'h03);
    exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(5); exp_q.push_back(1);
    req_i = 8'h2A;
    for (int k = 0; k < 4; k++) begin
      wait_grant();
      release_grant((k == 3) ? 8'h00 : 8'h2A);
    end
    apb_write(8'h10, 8'h01);
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
    req_i = 8'h2A;
    for (int k = 0; k < 3; k++) begin
      wait_grant();
      release_grant((k == 2) ? 8'h00 : 8'h2A);
    end
  endtask

  task automatic test_timeout();
    int n;
    apb_write(8'h00, 8'd7);
    exp_q.push_back(0);
    @(posedge pclk_i); #1;
    req_i = 8'h01;
    wait_grant();
    n = 1;
    @(posedge pclk_i); #1;
    req_i = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk_i);
      if (!gnt_valid_o) break;
      n++;
    end
    total++;
    if (n !== 4 || timeout_irq_o !== 1'b1) begin
      bad++; $display("FAIL timeout_hold: got cycles=%0d irq=%b, required 4 1", n, timeout_irq_o);
    end
    apb_read(8'h11, rd, er, rdy);
    total++;
    if (rd !== 8'h20) begin
      bad++; $display("FAIL timeout_status: got %02h, required 20", rd);
    end
    apb_write(8'h11, 8'h20);
    @(negedge pclk_i);
    total++;
    if (timeout_irq_o !== 1'b0) begin
      bad++; $display("FAIL timeout_clear: got irq=%b, required 0", timeout_irq_o);
    end
    // done on the last allowed hold cycle must not raise the flag
    exp_q.push_back(0);
    @(posedge pclk_i); #1;
    req_i = 8'h01;
    wait_grant();
    @(posedge pclk_i); #1;
    req_i = 8'h00;
    @(posedge pclk_i);
    @(posedge pclk_i); #1;
    done_i = 1'b1;
    @(negedge pclk_i);
    total++;
    if (gnt_valid_o !== 1'b1) begin
      bad++; $display("FAIL done_last_cycle_valid: got valid=%b, required 1", gnt_valid_o);
    end
    @(posedge pclk_i); #1;
    done_i = 1'b0;
    @(negedge pclk_i);
    total++;
    if (timeout_irq_o !== 1'b0 || gnt_valid_o !== 1'b0) begin
      bad++; $display("FAIL done_beats_timeout: got irq=%b valid=%b, required 0 0", timeout_irq_o, gnt_valid_o);
    end
  endtask

  task automatic test_masked();
    logic seen, got;
    seen = 1'b0;
    got = 1'b0;
    @(posedge pclk_i); #1;
    req_i = 8'h10;
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk_i);
      if (gnt_valid_o) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL masked_prio0: got a grant, required none");
    end
    exp_q.push_back(4);
    apb_write(8'h04, 8'hF1);
    for (int i = 0; i < 3 && !got; i++) begin
      @(negedge pclk_i);
      if (gnt_o === 8'h10) got = 1'b1;
    end
    total++;
    if (got !== 1'b1) begin
      bad++; $display("FAIL unmask_grant: got gnt=%02h, required 10 within 3 cycles", gnt_o);
    end
    release_grant(8'h00);
    apb_read(8'h04, rd, er, rdy);
    total++;
    if (rd !== 8'h01) begin
      bad++; $display("FAIL prio_upper_bits: got %02h, required 01", rd);
    end
  endtask

  task automatic test_reset_mid_grant();
    apb_write(8'h03, 8'd2);
    exp_q.push_back(3);
    @(posedge pclk_i); #1;
    req_i = 8'h08;
    wait_grant();
    #2;
    prst_i = 1'b0;
    #1;
    total++;
    if ({gnt_o, gnt_id_o, gnt_valid_o} !== '0) begin
      bad++; $display("FAIL async_reset_grant: got gnt=%02h id=%0d v=%b, required 0", gnt_o, gnt_id_o, gnt_valid_o);
    end
    req_i = 8'h00;
    @(negedge pclk_i);
    prst_i = 1'b1;
    apb_read(8'h03, rd, er, rdy);
    total++;
    if (rd !== 8'h00) begin
      bad++; $display("FAIL reset_prio_cleared: got %02h, required 00", rd);
    end
    apb_read(8'h10, rd, er, rdy);
    total++;
    if (rd !== 8'h01) begin
      bad++; $display("FAIL reset_ctrl_default: got %02h, required 01", rd);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_round_robin();
    test_timeout();
    test_masked();
    test_reset_mid_grant();
    repeat (3) @(negedge pclk_i);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: %0d grants outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_priority_arbiter.md
Name: apb_priority_arbiter

Overview:
- Shares one downstream resource, such as the interrupt service path or a shared bus port, between NUM_REQ requesters.
- Each requester has an APB-programmable 4-bit priority. Ties are broken round-robin.
- A grant is held until the owner signals done or a hold timeout expires.
- Sits beside the interrupt controller on the same APB slave bus and raises an interrupt line on timeout.

Parameters:
- NUM_REQ, 8, number of requesters (2..16).
- HOLD_MAX, 255, maximum grant duration in cycles before forced revoke (1..255).

Ports:
- pclk_i  in  1  clock.
- prst_i  in  1  reset; asynchronous, active-low.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable (access phase).
- pwrite_i  in  1  1 = write, 0 = read.
- paddr_i  in  8  APB address.
- pwdata_i  in  8  write data.
- prdata_o  out  8  read data.
- pready_o  out  1  access complete.
- pslverr_o  out  1  access error.
- req_i  in  NUM_REQ  request per requester; level, held until granted.
- gnt_o  out  NUM_REQ  one-hot grant.
- gnt_id_o  out  4  index of the granted requester.
- gnt_valid_o  out  1  grant active.
- done_i  in  1  owner releases the resource.
- timeout_irq_o  out  1  level; high while the sticky timeout flag is set.

Behaviour:
- Reset (prst_i low, asynchronous):
  - All outputs 0.
  - Priority registers 0; CTRL = 0x01 (enable=1); rr_ptr = 0.
  - hold_cnt = 0; timeout flag 0; state IDLE.
- Register map:
  - 0x00..NUM_REQ-1: PRIO[n], bits [3:0]; write bits [7:4] ignored, read as 0. PRIO = 0 masks requester n.
  - 0x10: CTRL. bit0 enable, bit1 rr_en (1 = round-robin tie-break, 0 = lowest index wins ties).
  - 0x11: STATUS, read-only. [3:0] gnt_id, [4] gnt_valid, [5] timeout flag. Write 1 to bit5 clears the flag; other write bits ignored.
- APB access:
  - Access completes when psel_i && penable_i, with pready_o = 1 for exactly that cycle (zero wait states).
  - Unmapped address: pslverr_o = 1 that cycle, write discarded, prdata_o = 0.
  - prdata_o is registered and valid in the pready_o cycle.
- State machine:
  - IDLE:
    - If enable and any (req_i[n] && PRIO[n] != 0), go to ARB; otherwise stay.
  - ARB (one cycle):
    - Select the maximum PRIO among eligible requesters.
    - Ties: with rr_en=1, the first tied index at or after rr_ptr, wrapping NUM_REQ-1 to 0; with rr_en=0, the lowest index.
    - Register the winner and go to GRANT.
    - If no requester is eligible in this cycle (request dropped), return to IDLE with no grant.
  - GRANT:
    - gnt_o, gnt_id_o and gnt_valid_o are driven from registers.
    - hold_cnt increments each cycle.
    - done_i = 1: go to RELEASE.
    - Else if hold_cnt == HOLD_MAX-1: set the timeout flag and go to RELEASE.
  - RELEASE (one cycle):
    - Drop gnt_o, gnt_valid_o and gnt_id_o to 0.
    - rr_ptr = winner+1 (wraps); hold_cnt = 0; go to IDLE.
- Latency: req_i rising at cycle N while in IDLE gives gnt_o at N+2. Minimum back-to-back grant spacing is 3 cycles (RELEASE, IDLE, ARB).
- Simultaneous events:
  - done_i in the same cycle as timeout: done wins, no flag.
  - STATUS write-clear in the same cycle as timeout set: set wins.
  - PRIO write during GRANT does not affect the current grant; it applies at the next ARB.
  - Clearing enable during GRANT: current grant runs to done or timeout; no new ARB.
- Reset mid-grant: gnt_o drops asynchronously; no release cycle.
- done_i outside GRANT is ignored.

Decomposition:
- Shared package arb_pkg:
  - State encoding: S_IDLE=2'b00, S_ARB=2'b01, S_GRANT=2'b10, S_RELEASE=2'b11.
  - Register address constants ADDR_CTRL=8'h10, ADDR_STATUS=8'h11; PRIO_W=4.
- One sub-module, arb_pick: combinational max-priority plus rotating tie-break over NUM_REQ. Inputs are eligible vector, priorities and rr_ptr; outputs are winner index and found.
- APB register file and FSM stay in the top.

Test Plan:
- Reset then read 0x10 → prdata_o 0x01. Read 0x03 → 0x00. Read 0x20 → pslverr_o 1, prdata_o 0.
- PRIO[2]=5, PRIO[6]=9; req_i=0x44 at cycle N → gnt_o=0x40, gnt_id_o=6 at N+2. done_i pulse → grant low next cycle; then gnt_o=0x04 three cycles later.
- PRIO[1]=PRIO[3]=PRIO[5]=4, rr_en=1, req_i=0x2A held, done_i after each grant → grant order 1,3,5,1. With rr_en=0 → 1,1,1.
- HOLD_MAX=4, grant requester 0, done_i never → gnt_valid_o low after 4 GRANT cycles, timeout_irq_o=1, STATUS=0x20. Write 0x20 to 0x11 → timeout_irq_o 0.
- PRIO[4]=0, req_i=0x10 only → no grant ever; write PRIO[4]=1 → gnt_o=0x10 within 3 cycles.
- Assert prst_i low mid-GRANT → gnt_o=0 immediately. After release, priorities read 0 and CTRL reads 0x01.
